// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state encoding and command bytes for the PS/2 host transmitter
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAITIDLE} ps2_state_e;
  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ECHO    = 8'hEE;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction
endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: 2-flop synchronizer with falling-edge detect on the synchronized level
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic level_o,
  output logic fall_o
);
  logic s1_q, s2_q, prev_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q <= pin_i;
      s2_q <= s1_q;
      prev_q <= s2_q;
    end
  end
  assign level_o = s2_q;
  assign fall_o = prev_q & ~s2_q;
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command byte transmitter with ACK check and watchdog
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       timeout
);
  localparam int MAXC = INHIBIT_CYCLES > TIMEOUT_CYCLES ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  ps2_state_e state_q;
  logic [9:0] frame_q;
  logic [3:0] bit_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic clk_oe_q, data_oe_q, done_q, ack_q, to_q;
  logic clk_lvl, clk_fall, data_lvl, data_fall_unused;
  ps2_sync_edge u_clk_sync (.clk(clk), .rst(rst), .pin_i(ps2_clk_in), .level_o(clk_lvl), .fall_o(clk_fall));
  ps2_sync_edge u_data_sync (.clk(clk), .rst(rst), .pin_i(ps2_data_in), .level_o(data_lvl), .fall_o(data_fall_unused));
  assign cnt_d = cnt_q + CW'(1);
  // done is raised while still busy, so tx_ready returns only on the following cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      frame_q <= '0;
      bit_q <= '0;
      cnt_q <= '0;
      clk_oe_q <= 1'b0;
      data_oe_q <= 1'b0;
      done_q <= 1'b0;
      ack_q <= 1'b0;
      to_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      to_q <= 1'b0;
      if (done_q) state_q <= IDLE;
      else case (state_q)
        IDLE: if (tx_valid) begin
          frame_q <= {1'b1, odd_parity(tx_data), tx_data};
          cnt_q <= '0;
          clk_oe_q <= 1'b1;
          ack_q <= 1'b0;
          state_q <= INHIBIT;
        end
        INHIBIT: begin
          cnt_q <= cnt_d;
          if (cnt_q == CW'(INHIBIT_CYCLES - 2)) data_oe_q <= 1'b1;
          if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
            clk_oe_q <= 1'b0;
            state_q <= REQ;
          end
        end
        REQ: begin
          cnt_q <= CW'(1);
          bit_q <= '0;
          state_q <= SEND;
        end
        default: begin
          cnt_q <= clk_fall ? '0 : cnt_d;
          if (!clk_fall && cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            clk_oe_q <= 1'b0;
            data_oe_q <= 1'b0;
            ack_q <= 1'b0;
            to_q <= 1'b1;
            done_q <= 1'b1;
          end else if (state_q == SEND && clk_fall) begin
            data_oe_q <= ~frame_q[bit_q];
            bit_q <= bit_q + 4'd1;
            if (bit_q == 4'd9) state_q <= ACK;
          end else if (state_q == ACK && clk_fall) begin
            ack_q <= ~data_lvl;
            state_q <= WAITIDLE;
          end else if (state_q == WAITIDLE && clk_lvl && data_lvl) done_q <= 1'b1;
        end
      endcase
    end
  end
  assign tx_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign done = done_q;
  assign ack_ok = ack_q;
  assign timeout = to_q;
endmodule
